// File: rtl/clock_pkg.sv
// clock_pkg: definitions shared by the clock datapath stages.
//   - btn_state_t : state encoding of the manual-button synchroniser/auto-repeat FSM
//   - BCD limits for the 24-hour range (00..23) and the 12-hour range (01..12)
//   - hour24_legal(): true when a digit pair is a reachable 24-hour value
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    // 24-hour limits: tens digit tops out at 2, and at tens == 2 the units wrap after 3
    localparam logic [1:0] HOUR_MSD_MAX  = 2'd2;
    localparam logic [3:0] HOUR_LSD_WRAP = 4'd3;
    localparam logic [3:0] BCD_MAX       = 4'd9;

    // 12-hour limits: display runs 12, 01..11, so tens tops out at 1 and 12 is the top value
    localparam logic [1:0] H12_MSD_MAX   = 2'd1;
    localparam logic [3:0] H12_LSD_TOP   = 4'd2;
    localparam logic [3:0] H12_LSD_PM    = 4'd1;

    function automatic logic hour24_legal(input logic [1:0] msd, input logic [3:0] lsd);
        return (lsd <= BCD_MAX) && (msd <= HOUR_MSD_MAX) &&
               !((msd == HOUR_MSD_MAX) && (lsd > HOUR_LSD_WRAP));
    endfunction

endpackage

// File: rtl/maq_h_if.sv
// maq_h_if: signal bundle between the hours stage and its environment.
//   enable_1hz    : one-cycle tick per second
//   inc_min       : minutes-advance qualifier
//   maqh_inc_hora : minutes carry (level, high while minutes == 59)
//   btn_inc_hora  : raw asynchronous set-hour button
//   maqh_lsd/msd  : hour digits (BCD)
//   maqh_inc_dia  : day carry
//   maqh_pm       : AM/PM flag, only present when MAQH_12H_EN is defined
// Modport slave is the hours stage; modport master is whoever drives it.
interface maq_h_if;
    logic       enable_1hz;
    logic       inc_min;
    logic       maqh_inc_hora;
    logic       btn_inc_hora;
    logic [3:0] maqh_lsd;
    logic [1:0] maqh_msd;
    logic       maqh_inc_dia;
`ifdef MAQH_12H_EN
    logic       maqh_pm;
`endif

    modport slave (
        input  enable_1hz, inc_min, maqh_inc_hora, btn_inc_hora,
`ifdef MAQH_12H_EN
        output maqh_pm,
`endif
        output maqh_lsd, maqh_msd, maqh_inc_dia
    );

    modport master (
        output enable_1hz, inc_min, maqh_inc_hora, btn_inc_hora,
`ifdef MAQH_12H_EN
        input  maqh_pm,
`endif
        input  maqh_lsd, maqh_msd, maqh_inc_dia
    );
endinterface

// File: rtl/maq_h_btn_sync_rep.sv
// btn_sync_rep: manual button conditioner, shared by the set-hour and set-minute paths.
//   clock      : system clock (rising edge)
//   reset      : asynchronous active-low reset
//   enable_1hz : one-cycle tick per second, paces the auto-repeat
//   btn_raw    : asynchronous active-high button
//   man_inc    : one-cycle increment request
// A press gives one immediate increment; holding it for REPEAT_DELAY ticks starts
// one increment per tick until release.
module btn_sync_rep
    import clock_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int REPEAT_DELAY = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic enable_1hz,
    input  logic btn_raw,
    output logic man_inc
);

    localparam int CNT_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_DELAY - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   btn_s;
    logic                   btn_q_reg;
    logic                   rise;
    btn_state_t             state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;

    // Synchroniser chain: bit 0 samples the raw button, the top bit is the clean level
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_reg  <= '0;
            btn_q_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], btn_raw};
            btn_q_reg <= btn_s;
        end
    end

    assign btn_s = sync_reg[SYNC_STAGES-1];
    assign rise  = btn_s & ~btn_q_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        man_inc    = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (rise) begin
                    man_inc    = 1'b1;
                    state_next = HOLD;
                    cnt_next   = '0;
                end
            end
            HOLD: begin
                if (!btn_s) begin
                    state_next = IDLE;
                end else if (enable_1hz) begin
                    // The tick that completes the delay only arms the repeat; it does not count
                    if (cnt_reg == CNT_LAST) begin
                        state_next = REPEAT;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            REPEAT: begin
                man_inc = enable_1hz;
                if (!btn_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/maq_h.sv
// maq_h: hours stage of the clock datapath.
//   maqh_clock : system clock (rising edge)
//   reset      : asynchronous active-low reset
//   bus        : maq_h_if.slave (tick, minutes carry, set-hour button, digits, day carry)
// Advances on the minutes carry (qualified by enable_1hz and inc_min) or on the
// conditioned set-hour button; coincident requests advance by one hour only.
// Optional MAQH_12H_EN: 12-hour display (12, 01..11) with AM/PM flag maqh_pm.
module maq_h
    import clock_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int REPEAT_DELAY = 2
) (
    input  logic     maqh_clock,
    input  logic     reset,
    maq_h_if.slave   bus
);

    logic       auto_inc;
    logic       man_inc;
    logic       inc;
    logic [3:0] lsd_reg, lsd_next;
    logic [1:0] msd_reg, msd_next;

    btn_sync_rep #(
        .SYNC_STAGES  (SYNC_STAGES),
        .REPEAT_DELAY (REPEAT_DELAY)
    ) u_btn (
        .clock      (maqh_clock),
        .reset      (reset),
        .enable_1hz (bus.enable_1hz),
        .btn_raw    (bus.btn_inc_hora),
        .man_inc    (man_inc)
    );

    // Same qualification the minutes stage uses to wrap 59 -> 00, so both move on one edge
    assign auto_inc = bus.enable_1hz & bus.inc_min & bus.maqh_inc_hora;
    assign inc      = auto_inc | man_inc;

`ifdef MAQH_12H_EN
    logic pm_reg, pm_next;
    logic legal12;

    assign legal12 = (lsd_reg <= BCD_MAX) && (msd_reg <= H12_MSD_MAX) &&
                     !((msd_reg == H12_MSD_MAX) && (lsd_reg > H12_LSD_TOP)) &&
                     !((msd_reg == 2'd0) && (lsd_reg == 4'd0));

    always_ff @(posedge maqh_clock or negedge reset) begin
        if (!reset) begin
            msd_reg <= H12_MSD_MAX;
            lsd_reg <= H12_LSD_TOP;
            pm_reg  <= 1'b0;
        end else begin
            msd_reg <= msd_next;
            lsd_reg <= lsd_next;
            pm_reg  <= pm_next;
        end
    end

    always_comb begin
        lsd_next = lsd_reg;
        msd_next = msd_reg;
        pm_next  = pm_reg;
        if (inc) begin
            if (!legal12) begin
                msd_next = H12_MSD_MAX;
                lsd_next = H12_LSD_TOP;
            end else if ((msd_reg == H12_MSD_MAX) && (lsd_reg == H12_LSD_TOP)) begin
                // 12 -> 01: the meridiem flips on the way into 12, not out of it
                msd_next = 2'd0;
                lsd_next = 4'd1;
            end else if ((msd_reg == H12_MSD_MAX) && (lsd_reg == H12_LSD_PM)) begin
                lsd_next = H12_LSD_TOP;
                pm_next  = ~pm_reg;
            end else if (lsd_reg == BCD_MAX) begin
                lsd_next = '0;
                msd_next = msd_reg + 1'b1;
            end else begin
                lsd_next = lsd_reg + 1'b1;
            end
        end
    end

    assign bus.maqh_pm      = pm_reg;
    assign bus.maqh_inc_dia = (msd_reg == H12_MSD_MAX) && (lsd_reg == H12_LSD_PM) &&
                              pm_reg && bus.maqh_inc_hora;
`else
    always_ff @(posedge maqh_clock or negedge reset) begin
        if (!reset) begin
            msd_reg <= '0;
            lsd_reg <= '0;
        end else begin
            msd_reg <= msd_next;
            lsd_reg <= lsd_next;
        end
    end

    always_comb begin
        lsd_next = lsd_reg;
        msd_next = msd_reg;
        if (inc) begin
            // A corrupted digit pair recovers to 00 on the next increment
            if (!hour24_legal(msd_reg, lsd_reg) ||
                ((msd_reg == HOUR_MSD_MAX) && (lsd_reg == HOUR_LSD_WRAP))) begin
                msd_next = '0;
                lsd_next = '0;
            end else if (lsd_reg == BCD_MAX) begin
                lsd_next = '0;
                msd_next = msd_reg + 1'b1;
            end else begin
                lsd_next = lsd_reg + 1'b1;
            end
        end
    end

    assign bus.maqh_inc_dia = (msd_reg == HOUR_MSD_MAX) && (lsd_reg == HOUR_LSD_WRAP) &&
                              bus.maqh_inc_hora;
`endif

    assign bus.maqh_lsd = lsd_reg;
    assign bus.maqh_msd = msd_reg;

endmodule

// File: tb/tb_maq_h.sv
// tb_maq_h: directed, table-driven bench for the 24-hour build of maq_h.
module tb_maq_h;

    logic maqh_clock;
    logic reset;

    maq_h_if bus();

    maq_h #(
        .SYNC_STAGES  (2),
        .REPEAT_DELAY (2)
    ) dut (
        .maqh_clock (maqh_clock),
        .reset      (reset),
        .bus        (bus)
    );

    initial maqh_clock = 1'b0;
    always #5 maqh_clock = ~maqh_clock;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic       en;
        logic       imin;
        logic       ihora;
        logic [7:0] exp_hour;   // BCD tens:units
        logic       exp_dia;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic logic [7:0] hour_now();
        return {2'b00, bus.maqh_msd, bus.maqh_lsd};
    endfunction

    // One clock with the given levels; outputs sampled 1 ns after the edge
    task automatic cyc(input logic en, input logic imin, input logic ihora);
        bus.enable_1hz    = en;
        bus.inc_min       = imin;
        bus.maqh_inc_hora = ihora;
        @(posedge maqh_clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.btn_inc_hora = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 8'h01, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 8'h02, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 8'h03, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 8'h04, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 8'h05, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 8'h06, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 8'h07, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'h08, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'h09, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 8'h10, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 8'h10, 1'b0};   // inc_min low gates
        vecs[11] = '{1'b0, 1'b1, 1'b1, 8'h10, 1'b0};   // no tick
        vecs[12] = '{1'b1, 1'b1, 1'b0, 8'h10, 1'b0};   // no minutes carry
        vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h10, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 8'h11, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b0};

        bus.enable_1hz    = 1'b0;
        bus.inc_min       = 1'b0;
        bus.maqh_inc_hora = 1'b0;
        bus.btn_inc_hora  = 1'b0;
        reset = 1'b0;

        // Reset state, with the carry input high to show the day carry stays low
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        check("reset_hour", hour_now(), 8'h00);
        check("reset_dia", {7'b0, bus.maqh_inc_dia}, 8'h00);
        reset = 1'b1;

        // Count a little, then pull reset asynchronously between edges
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        check("pre_midreset", hour_now(), 8'h03);
        #2 reset = 1'b0;
        #1 check("async_midreset", hour_now(), 8'h00);
        cyc(1'b1, 1'b1, 1'b1);
        check("held_in_reset", hour_now(), 8'h00);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            cyc(vecs[i].en, vecs[i].imin, vecs[i].ihora);
            check($sformatf("vec%0d_hour", i), hour_now(), vecs[i].exp_hour);
            check($sformatf("vec%0d_dia", i), {7'b0, bus.maqh_inc_dia}, {7'b0, vecs[i].exp_dia});
        end

        // Wrap: 23 carries from 00 reach 23, then day carry and 23 -> 00
        do_reset();
        for (int i = 0; i < 23; i++) cyc(1'b1, 1'b1, 1'b1);
        check("reach_23", hour_now(), 8'h23);
        bus.enable_1hz = 1'b0;
        #1 check("dia_at_23", {7'b0, bus.maqh_inc_dia}, 8'h01);
        bus.maqh_inc_hora = 1'b0;
        #1 check("dia_23_no_carry", {7'b0, bus.maqh_inc_dia}, 8'h00);
        cyc(1'b1, 1'b1, 1'b1);
        check("wrap_00", hour_now(), 8'h00);
        check("dia_after_wrap", {7'b0, bus.maqh_inc_dia}, 8'h00);

        // Single press held 5 cycles: one increment, on the third edge after the rise
        bus.btn_inc_hora = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        check("btn_edge1", hour_now(), 8'h00);
        cyc(1'b0, 1'b0, 1'b0);
        check("btn_edge2", hour_now(), 8'h00);
        cyc(1'b0, 1'b0, 1'b0);
        check("btn_edge3", hour_now(), 8'h01);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        bus.btn_inc_hora = 1'b0;
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0);
        check("btn_single_total", hour_now(), 8'h01);

        // Auto-repeat: press plus 6 ticks held -> 1 + 4 increments
        do_reset();
        bus.btn_inc_hora = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
        check("rep_first", hour_now(), 8'h01);
        for (int t = 0; t < 6; t++) begin
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
        check("rep_total", hour_now(), 8'h05);
        bus.btn_inc_hora = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 3; t++) begin
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
        check("rep_released_idle", hour_now(), 8'h05);

        // Coincident button rise and minutes carry at 09 -> 10, not 11
        do_reset();
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 1'b1);
        check("sim_pre", hour_now(), 8'h09);
        bus.btn_inc_hora = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("sim_before", hour_now(), 8'h09);
        cyc(1'b1, 1'b1, 1'b1);
        check("sim_both", hour_now(), 8'h10);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
        bus.btn_inc_hora = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
        check("sim_after", hour_now(), 8'h10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/maq_h.md
Name: maq_h

Overview:
- Hours stage of the clock datapath. It sits downstream of the minutes machine and consumes that machine's minutes-wrap carry.
- Holds the hour as two BCD digits, 00..23. It advances on the minutes carry or on a manual set-hour button.
- The manual button has synchronisation, edge detection and auto-repeat.
- Emits a day-carry for a future day/date stage.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on the asynchronous button input (minimum 2).
- REPEAT_DELAY, 2: number of enable_1hz ticks the button must be held before auto-repeat starts.

Ports:
- maqh_clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable_1hz  in  1  one-cycle tick, once per second.
- inc_min  in  1  minutes-advance qualifier; same signal the minutes stage uses.
- maqh_inc_hora  in  1  minutes carry; level, high while minutes == 59.
- btn_inc_hora  in  1  raw manual set-hour button; asynchronous, active-high.
- maqh_lsd  out  4  hour units digit, BCD 0..9.
- maqh_msd  out  2  hour tens digit, 0..2.
- maqh_inc_dia  out  1  day carry; combinational, high while hour == 23 and maqh_inc_hora == 1.

Behaviour:
- Reset (reset == 0, asynchronous): maqh_lsd = 0, maqh_msd = 0, synchroniser cleared, FSM in IDLE, repeat counter = 0.
  - maqh_inc_dia evaluates to 0 during reset.
  - Reset mid-hold: after release, FSM stays IDLE until a fresh rising edge is seen on the synchronised button.
- Auto carry:
  - auto_inc = enable_1hz & inc_min & maqh_inc_hora.
  - The hour register updates on the same edge the minutes stage wraps 59 -> 00.
- Button path:
  - btn_inc_hora passes through SYNC_STAGES flip-flops, giving btn_s.
  - btn_s is registered once more; rise = btn_s & ~btn_q.
- Button FSM, one cycle per transition:
  - IDLE: on rise, man_inc = 1 and go to HOLD; repeat counter = 0.
  - HOLD: if !btn_s, go to IDLE. Otherwise on each enable_1hz, counter++. When counter reaches REPEAT_DELAY-1 and enable_1hz, go to REPEAT.
  - REPEAT: man_inc = enable_1hz (one hour per second while held). If !btn_s, go to IDLE.
- Increment rule:
  - inc = auto_inc | man_inc.
  - A simultaneous auto and manual event advances the hour by exactly one, never two.
- Counting, per inc:
  - If msd == 2 and lsd == 3: next value 00 (wrap).
  - Else if lsd == 9: lsd = 0, msd + 1.
  - Else: lsd + 1.
- Illegal states (lsd > 9, or msd == 3, or msd == 2 with lsd > 3) are never produced. If forced, the next inc loads 00.
- Latency: outputs change on the clock edge following the qualifying tick. Button-to-first-increment latency is SYNC_STAGES + 1 cycles.
- Digit registers hold when inc == 0.

Optional Feature:
- Macro: MAQH_12H_EN.
- Defined:
  - Display range is 12, 01..11, then 12; with msd 0..1.
  - Extra output maqh_pm (1 bit, reset 0) toggles when the display goes 11 -> 12.
  - Reset value of the display is 12 with maqh_pm = 0 (midnight).
  - maqh_inc_dia is high when display == 11, maqh_pm == 1 and maqh_inc_hora == 1.
- Undefined: 24-hour behaviour as above; maqh_pm port absent.

Decomposition:
- Shared package clock_pkg holds:
  - The btn FSM state enum (IDLE, HOLD, REPEAT).
  - BCD limit constants: HOUR_MSD_MAX = 2, HOUR_LSD_WRAP = 3, BCD_MAX = 9.
  - The 12-hour limits.
- One sub-module is natural: btn_sync_rep.
  - Contains the synchroniser, edge detector and auto-repeat FSM.
  - Output is a one-cycle man_inc pulse.
  - The same sub-module is reused later for a manual set-minute button.

Test Plan:
- Reset then auto count: assert reset = 0 mid-count, release; pulse enable_1hz with inc_min = 1 and maqh_inc_hora = 1 ten times -> hour 00, then 10 (msd = 1, lsd = 0).
- Wrap: preload to 23 via 23 carries; with maqh_inc_hora = 1 -> maqh_inc_dia = 1. Next tick -> 00 and maqh_inc_dia = 0.
- Gating: enable_1hz = 1, maqh_inc_hora = 1, inc_min = 0 -> hour unchanged. With enable_1hz = 0 and the others high -> hour unchanged.
- Button single press: pulse btn_inc_hora for 5 cycles -> exactly one increment, SYNC_STAGES + 1 cycles after the rising edge.
- Auto-repeat: hold btn_inc_hora across 6 enable_1hz ticks with REPEAT_DELAY = 2 -> 1 + 4 = 5 increments (hour 00 -> 05). Release -> FSM in IDLE.
- Simultaneous events: button rise lands on the same cycle as auto_inc at hour 09 -> hour 10, not 11.
